// File: rtl/wb256_gather.sv
// wb256_gather: packs a burst of WORD_W-bit stream beats into one
// WORD_W*BEATS-bit value and issues a single-cycle register-file write.
module wb256_gather #(
  parameter int WORD_W = 32,
  parameter int BEATS  = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [4:0]                DEST,
  input  logic                      ABORT,
  input  logic                      IN_VALID,
  input  logic [WORD_W-1:0]         IN_DATA,
  output logic                      IN_READY,
  output logic [WORD_W*BEATS-1:0]   WB,
  output logic [4:0]                A3,
  output logic                      WE,
  output logic                      BUSY,
  output logic                      ERR
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATHER,
    S_WRITE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [CNT_W-1:0]          r_count;
  logic [WORD_W*BEATS-1:0]   r_buf;
  logic [4:0]                r_a3;
  logic                      r_err;
  logic                      w_xfer;
  logic                      w_start_ok;

  // ABORT masks IN_READY so a beat offered alongside it is never taken
  assign IN_READY   = (r_state == S_GATHER) && !ABORT;
  assign w_xfer     = IN_READY && IN_VALID;
  assign w_start_ok = (r_state == S_IDLE) && START;

  assign WE   = (r_state == S_WRITE);
  assign BUSY = (r_state != S_IDLE);
  assign WB   = r_buf;
  assign A3   = r_a3;
  assign ERR  = r_err;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (START) w_next = S_GATHER;
      end
      S_GATHER: begin
        if (ABORT)                               w_next = S_IDLE;
        else if (w_xfer && r_count == LAST_BEAT) w_next = S_WRITE;
      end
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Beat counter, packing buffer and latched destination
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
      r_buf   <= '0;
      r_a3    <= '0;
    end else if (w_start_ok) begin
      r_a3    <= DEST;
      r_buf   <= '0;
      r_count <= '0;
    end else if (r_state == S_GATHER) begin
      if (ABORT) begin
        r_count <= '0;
      end else if (w_xfer) begin
        r_buf[int'(r_count)*WORD_W +: WORD_W] <= IN_DATA;
        r_count <= (r_count == LAST_BEAT) ? '0 : r_count + CNT_W'(1);
      end
    end
  end

  // Sticky error: START arriving while a gather or write is in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                            r_err <= 1'b0;
    else if (START && r_state != S_IDLE) r_err <= 1'b1;
  end

endmodule

// File: tb/tb_wb256_gather.sv
// Directed bench for wb256_gather with hand-computed expectations.
module tb_wb256_gather;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [4:0]   DEST = '0;
  logic         ABORT = 1'b0;
  logic         IN_VALID = 1'b0;
  logic [31:0]  IN_DATA = '0;
  logic         IN_READY;
  logic [255:0] WB;
  logic [4:0]   A3;
  logic         WE;
  logic         BUSY;
  logic         ERR;

  int unsigned  n_tests = 0;
  int unsigned  n_fail  = 0;
  int unsigned  cyc     = 0;
  logic         prev_we = 1'b0;
  logic         we_seen;

  wb256_gather #(.WORD_W(32), .BEATS(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .DEST     (DEST),
    .ABORT    (ABORT),
    .IN_VALID (IN_VALID),
    .IN_DATA  (IN_DATA),
    .IN_READY (IN_READY),
    .WB       (WB),
    .A3       (A3),
    .WE       (WE),
    .BUSY     (BUSY),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // WE must never stay high into a second consecutive cycle
  always @(negedge CLK) begin
    if (WE === 1'b1) check("we_single_cycle", 256'(prev_we), 256'(0));
    prev_we = WE;
  end

  // Runs one burst starting in the current cycle (caller is just after a posedge).
  // Returns just after the posedge that ends WRITE, so a follow-up START lands
  // in the cycle right after WE.
  task automatic do_burst(input logic [4:0] dest, input int unsigned stall_at,
                          input int unsigned stall_len, input int unsigned err_at,
                          input logic [31:0] base, input logic incr, input string tag);
    logic [255:0] exp_wb;
    int unsigned  t0;
    for (int k = 0; k < 8; k++)
      exp_wb[k*32 +: 32] = incr ? base + 32'(k) : base;
    START = 1'b1;
    DEST  = dest;
    t0    = cyc;
    @(posedge CLK); #1;
    START = 1'b0;
    DEST  = 5'd31;
    for (int unsigned k = 0; k < 8; k++) begin
      if (k == stall_at) begin
        for (int unsigned s = 0; s < stall_len; s++) begin
          IN_VALID = 1'b0;
          IN_DATA  = 32'hFFFF_FFFF;
          @(negedge CLK);
          check({tag, "_rdy_stall"}, 256'(IN_READY), 256'(1));
          @(posedge CLK); #1;
        end
      end
      IN_VALID = 1'b1;
      IN_DATA  = incr ? base + k : base;
      if (k == err_at) begin
        START = 1'b1;
        DEST  = 5'd7;
      end
      @(negedge CLK);
      check({tag, "_rdy"}, 256'(IN_READY), 256'(1));
      @(posedge CLK); #1;
      START = 1'b0;
      DEST  = 5'd31;
    end
    IN_VALID = 1'b0;
    @(negedge CLK);
    check({tag, "_we"},      256'(WE),        256'(1));
    check({tag, "_a3"},      256'(A3),        256'(dest));
    check({tag, "_wb"},      WB,              exp_wb);
    check({tag, "_latency"}, 256'(cyc - t0),  256'(9 + stall_len));
    check({tag, "_rdy_wr"},  256'(IN_READY),  256'(0));
    check({tag, "_busy_wr"}, 256'(BUSY),      256'(1));
    @(posedge CLK); #1;
    check({tag, "_we_off"},  256'(WE),        256'(0));
    check({tag, "_busy_off"},256'(BUSY),      256'(0));
    check({tag, "_a3_hold"}, 256'(A3),        256'(dest));
    check({tag, "_wb_hold"}, WB,              exp_wb);
  endtask

  initial begin
    // Reset values
    #2 RST = 1'b0;
    #1;
    check("rst_we",   256'(WE),       256'(0));
    check("rst_busy", 256'(BUSY),     256'(0));
    check("rst_rdy",  256'(IN_READY), 256'(0));
    check("rst_err",  256'(ERR),      256'(0));
    check("rst_a3",   256'(A3),       256'(0));
    check("rst_wb",   WB,             256'(0));
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;

    // ABORT in IDLE does nothing
    ABORT = 1'b1;
    @(negedge CLK);
    check("idle_abort_busy", 256'(BUSY), 256'(0));
    @(posedge CLK); #1;
    ABORT = 1'b0;

    // Basic burst to DEST=2, beats 1..8
    do_burst(5'd2, 99, 0, 99, 32'h1, 1'b1, "basic");
    check("basic_wb_value", WB,
          256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);

    // Same burst with a 3-cycle IN_VALID gap after beat 4
    do_burst(5'd2, 4, 3, 99, 32'h1, 1'b1, "stall");

    // Abort after 5 beats with a 6th beat offered
    START = 1'b1; DEST = 5'd1;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      IN_VALID = 1'b1; IN_DATA = 32'h1111_0000 + k;
      @(posedge CLK); #1;
    end
    IN_DATA = 32'hDEAD_BEEF; ABORT = 1'b1;
    @(negedge CLK);
    check("abort_rdy", 256'(IN_READY), 256'(0));
    check("abort_we",  256'(WE),       256'(0));
    @(posedge CLK); #1;
    ABORT = 1'b0; IN_VALID = 1'b0;
    check("abort_idle_busy", 256'(BUSY), 256'(0));
    we_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (WE) we_seen = 1'b1;
    end
    check("abort_no_we", 256'(we_seen), 256'(0));
    @(posedge CLK); #1;
    do_burst(5'd3, 99, 0, 99, 32'hA5A5_A5A5, 1'b0, "a5");
    check("err_still_clear", 256'(ERR), 256'(0));

    // START during GATHER: ERR sets, gather continues with original A3
    do_burst(5'd9, 99, 0, 3, 32'h100, 1'b1, "errg");
    check("err_set", 256'(ERR), 256'(1));
    @(posedge CLK); @(posedge CLK); #1;
    check("err_sticky", 256'(ERR), 256'(1));

    // Reset after 6 beats
    START = 1'b1; DEST = 5'd4;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int unsigned k = 0; k < 6; k++) begin
      IN_VALID = 1'b1; IN_DATA = 32'h2000 + k;
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    #1;
    check("mid_rst_we",   256'(WE),   256'(0));
    check("mid_rst_busy", 256'(BUSY), 256'(0));
    check("mid_rst_wb",   WB,         256'(0));
    check("mid_rst_err",  256'(ERR),  256'(0));
    check("mid_rst_a3",   256'(A3),   256'(0));
    @(negedge CLK);
    RST = 1'b1;
    we_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (WE) we_seen = 1'b1;
    end
    check("mid_rst_no_write", 256'(we_seen), 256'(0));
    IN_VALID = 1'b0;
    @(posedge CLK); #1;

    // Back-to-back bursts, second START the cycle after WE
    do_burst(5'd0, 99, 0, 99, 32'h3000_0000, 1'b1, "b2b0");
    do_burst(5'd1, 99, 0, 99, 32'h4000_0000, 1'b1, "b2b1");
    check("b2b_err_clear", 256'(ERR), 256'(0));

    @(posedge CLK); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
